// File: rtl/sm_accum.sv
// Sequential sign-magnitude accumulator: sums one signed term per accepted beat
// and emits a registered, saturated sign-magnitude sum per packet.
module sm_accum #(
  parameter int DATA_W = 23,
  parameter int ACC_W  = 26,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sat,
  output logic [CNT_W-1:0]  out_count
);

  localparam int MAG_W = DATA_W - 1;
  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};
  localparam logic [ACC_W-1:0] OUT_LIM = ACC_W'({MAG_W{1'b1}});
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_in_ready;
  logic               r_acc_sign;
  logic [ACC_W-1:0]   r_acc_mag;
  logic               r_ovf;
  logic [CNT_W-1:0]   r_count;
  logic [DATA_W-1:0]  r_out_data;
  logic               r_out_valid;
  logic               r_out_sat;
  logic [CNT_W-1:0]   r_out_count;

  logic               w_accept;
  logic [ACC_W-1:0]   w_term_mag;
  logic               w_term_sign;
  logic [ACC_W:0]     w_sum;
  logic [ACC_W-1:0]   w_nxt_mag;
  logic               w_raw_sign;
  logic               w_nxt_sign;
  logic               w_nxt_ovf;
  logic [CNT_W-1:0]   w_nxt_count;
  logic               w_out_sat;
  logic [DATA_W-1:0]  w_out_data;

  assign w_accept    = in_valid & r_in_ready;
  assign w_term_mag  = ACC_W'(in_data[MAG_W-1:0]);
  // A -0 term behaves exactly like +0.
  assign w_term_sign = in_data[DATA_W-1] & (|in_data[MAG_W-1:0]);
  assign w_sum       = {1'b0, r_acc_mag} + {1'b0, w_term_mag};

  // Sign-magnitude add of the incoming term into the accumulator, with clamp.
  always_comb begin
    w_nxt_mag  = r_acc_mag;
    w_raw_sign = r_acc_sign;
    w_nxt_ovf  = r_ovf;
    if (r_acc_sign == w_term_sign) begin
      if (w_sum[ACC_W]) begin
        w_nxt_mag = ACC_MAX;
        w_nxt_ovf = 1'b1;
      end else begin
        w_nxt_mag = w_sum[ACC_W-1:0];
      end
    end else if (r_acc_mag >= w_term_mag) begin
      w_nxt_mag = r_acc_mag - w_term_mag;
    end else begin
      w_nxt_mag  = w_term_mag - r_acc_mag;
      w_raw_sign = w_term_sign;
    end
  end

  assign w_nxt_sign  = w_raw_sign & (|w_nxt_mag);
  assign w_nxt_count = (r_count == CNT_MAX) ? r_count : r_count + CNT_W'(1);
  assign w_out_sat   = w_nxt_ovf | (w_nxt_mag > OUT_LIM);
  assign w_out_data  = w_out_sat ? {w_nxt_sign, {MAG_W{1'b1}}}
                                 : {w_nxt_sign, w_nxt_mag[MAG_W-1:0]};

  // Packet FSM, accumulator state and registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_acc_sign  <= 1'b0;
      r_acc_mag   <= '0;
      r_ovf       <= 1'b0;
      r_count     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_sat   <= 1'b0;
      r_out_count <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_ACC: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_acc_sign <= w_nxt_sign;
            r_acc_mag  <= w_nxt_mag;
            r_ovf      <= w_nxt_ovf;
            r_count    <= w_nxt_count;
            if (in_last) begin
              r_state     <= S_DONE;
              r_in_ready  <= 1'b0;
              r_out_data  <= w_out_data;
              r_out_sat   <= w_out_sat;
              r_out_count <= w_nxt_count;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= S_ACC;
            end
          end
        end
        S_DONE: begin
          if (r_out_valid && out_ready) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_acc_sign  <= 1'b0;
            r_acc_mag   <= '0;
            r_ovf       <= 1'b0;
            r_count     <= '0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_sat   = r_out_sat;
  assign out_count = r_out_count;

endmodule

// File: tb/tb_sm_accum.sv
// Self-checking bench for sm_accum: vector table plus scoreboard of packet sums.
module tb_sm_accum;

  logic        clk;
  logic        rst_n;
  logic [22:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [22:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sat;
  logic [7:0]  out_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [22:0] data;
    logic        last;
    logic [22:0] exp_data;
    logic        exp_sat;
    logic [7:0]  exp_cnt;
  } vec_t;

  typedef struct {
    logic [22:0] d;
    logic        s;
    logic [7:0]  c;
  } exp_t;

  vec_t vecs[14];
  exp_t sb[$];

  sm_accum #(.DATA_W(23), .ACC_W(26), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sat(out_sat), .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void push(input logic [22:0] d, input logic s, input logic [7:0] c);
    exp_t e;
    e.d = d; e.s = s; e.c = c;
    sb.push_back(e);
  endfunction

  // Scoreboard: compare each handshaken sum against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", {9'd0, out_data}, {9'd0, e.d});
        chk("out_sat", {31'd0, out_sat}, {31'd0, e.s});
        chk("out_count", {24'd0, out_count}, {24'd0, e.c});
      end
    end
  end

  task automatic beat(input logic [22:0] d, input logic l);
    bit ok;
    int n;
    in_data = d; in_valid = 1'b1; in_last = l;
    ok = 1'b0; n = 0;
    while (!ok && n < 64) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!ok) chk("beat_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", sb.size(), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{23'h000005, 1'b0, 23'h0,      1'b0, 8'd0};
    vecs[1]  = '{23'h000007, 1'b0, 23'h0,      1'b0, 8'd0};
    vecs[2]  = '{23'h400003, 1'b1, 23'h000009, 1'b0, 8'd3};
    vecs[3]  = '{23'h000064, 1'b0, 23'h0,      1'b0, 8'd0};
    vecs[4]  = '{23'h400064, 1'b1, 23'h000000, 1'b0, 8'd2};
    vecs[5]  = '{23'h400000, 1'b1, 23'h000000, 1'b0, 8'd1};
    vecs[6]  = '{23'h3FFFFF, 1'b0, 23'h0,      1'b0, 8'd0};
    vecs[7]  = '{23'h3FFFFF, 1'b1, 23'h3FFFFF, 1'b1, 8'd2};
    vecs[8]  = '{23'h000001, 1'b1, 23'h000001, 1'b0, 8'd1};
    vecs[9]  = '{23'h400005, 1'b0, 23'h0,      1'b0, 8'd0};
    vecs[10] = '{23'h000002, 1'b1, 23'h400003, 1'b0, 8'd2};
    vecs[11] = '{23'h7FFFFF, 1'b0, 23'h0,      1'b0, 8'd0};
    vecs[12] = '{23'h400001, 1'b1, 23'h7FFFFF, 1'b1, 8'd2};
    vecs[13] = '{23'h400007, 1'b1, 23'h400007, 1'b0, 8'd1};

    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {9'd0, out_data}, 32'd0);
    chk("rst_out_sat", {31'd0, out_sat}, 32'd0);
    chk("rst_out_count", {24'd0, out_count}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].last) push(vecs[i].exp_data, vecs[i].exp_sat, vecs[i].exp_cnt);
      beat(vecs[i].data, vecs[i].last);
      if (vecs[i].last) begin
        chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
        chk("done_in_ready", {31'd0, in_ready}, 32'd0);
      end
    end
    drain();

    // Accumulator clamp: true sum fits, but the sticky flag must force saturation.
    push(23'h3FFFFF, 1'b1, 8'd33);
    for (int i = 0; i < 17; i++) beat(23'h3FFFFF, 1'b0);
    for (int i = 0; i < 16; i++) beat(23'h7FFFFF, (i == 15) ? 1'b1 : 1'b0);
    drain();

    out_ready = 1'b0;
    push(23'h000009, 1'b0, 8'd1);
    beat(23'h000009, 1'b1);
    in_data = 23'h000002; in_valid = 1'b1; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_out_data", {9'd0, out_data}, 32'h000009);
      chk("hold_out_count", {24'd0, out_count}, 32'd1);
    end
    @(posedge clk);
    #1;
    push(23'h000002, 1'b0, 8'd1);
    out_ready = 1'b1;
    beat(23'h000002, 1'b1);
    drain();

    beat(23'h000003, 1'b0);
    beat(23'h000006, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(23'h000004, 1'b0, 8'd1);
    beat(23'h000004, 1'b1);
    drain();

    push(23'h000000, 1'b0, 8'd255);
    for (int i = 0; i < 300; i++) begin
      beat((i % 2 == 1) ? 23'h400001 : 23'h000001, (i == 299) ? 1'b1 : 1'b0);
      if (i % 4 == 1) begin
        @(posedge clk);
        #1;
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
